// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Purpose  : MEM-stage load/store unit. Issues one RAM access per memory op  |
// |            over a req/ready handshake, stalls the pipeline while it is     |
// |            outstanding, and feeds MEM/WB with either the ALU result or     |
// |            aligned, sign/zero-extended load data.                          |
// | Ports    : clk, rst (async, active-low)                                    |
// |            EX/MEM in : opcode_in, funct3_in, rd_addr_in, rd_data_in,       |
// |                        rs2_data_in, ram_addr_in                            |
// |            RAM       : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,    |
// |                        mem_rdata, mem_ready                                |
// |            MEM/WB    : opcode_out, rd_addr_out, rd_data_out                |
// |            Status    : stall_req, misalign_err, bus_err                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rd_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] ram_addr_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [6:0]  opcode_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_data_out,
  output logic        stall_req,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [6:0]       C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       C_OP_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             misalign_err_q, misalign_err_d;
  logic             bus_err_q, bus_err_d;

  // ---------------------------------------------------------------------------
  // Decode of the op currently presented by EX/MEM
  // ---------------------------------------------------------------------------
  logic        w_is_load, w_is_store, w_legal, w_misaligned, w_access_ok, w_access_bad;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_is_load  = (opcode_in == C_OP_LOAD);
  assign w_is_store = (opcode_in == C_OP_STORE);

  always_comb begin
    w_legal = 1'b0;
    if (w_is_load) begin
      case (funct3_in)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end else if (w_is_store) begin
      w_legal = (funct3_in[2] == 1'b0) && (funct3_in[1:0] != 2'b11);
    end
  end

  // funct3[1:0] encodes the access size for both loads and stores.
  assign w_misaligned = ((funct3_in[1:0] == 2'b01) && ram_addr_in[0]) ||
                        ((funct3_in[1:0] == 2'b10) && (ram_addr_in[1:0] != 2'b00));
  assign w_access_ok  = (w_is_load || w_is_store) && w_legal && !w_misaligned;
  assign w_access_bad = (w_is_load || w_is_store) && !(w_legal && !w_misaligned);
  assign w_cnt_inc    = cnt_q + 1'b1;

  // Store lane replication and byte enables.
  always_comb begin
    w_wdata = rs2_data_in;
    w_wstrb = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        w_wdata = {4{rs2_data_in[7:0]}};
        w_wstrb = 4'b0001 << ram_addr_in[1:0];
      end
      2'b01: begin
        w_wdata = {2{rs2_data_in[15:0]}};
        w_wstrb = 4'b0011 << {ram_addr_in[1], 1'b0};
      end
      default: begin
        w_wdata = rs2_data_in;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction uses the funct3/offset captured at issue time.
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_ext;

  always_comb begin
    w_lane_byte = mem_rdata[{off_q, 3'b000} +: 8];
    w_lane_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  w_load_ext = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b001:  w_load_ext = {{16{w_lane_half[15]}}, w_lane_half};
      3'b100:  w_load_ext = {24'd0, w_lane_byte};
      3'b101:  w_load_ext = {16'd0, w_lane_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wstrb_d    = mem_wstrb_q;
    load_data_d    = load_data_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    misalign_err_d = 1'b0;
    bus_err_d      = 1'b0;
    stall_req      = 1'b0;
    opcode_out     = opcode_in;
    rd_addr_out    = w_is_store ? 5'd0 : rd_addr_in;
    rd_data_out    = rd_data_in;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_access_ok) begin
          stall_req   = 1'b1;
          // Bubble to MEM/WB while the access is outstanding.
          rd_addr_out = 5'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = w_is_store;
          mem_addr_d  = {ram_addr_in[31:2], 2'b00};
          mem_wdata_d = w_is_store ? w_wdata : 32'd0;
          mem_wstrb_d = w_is_store ? w_wstrb : 4'b0000;
          funct3_d    = funct3_in;
          off_d       = ram_addr_in[1:0];
          state_d     = ST_BUSY;
        end else if (w_access_bad) begin
          rd_addr_out    = 5'd0;
          misalign_err_d = 1'b1;
        end
      end

      ST_BUSY: begin
        stall_req   = 1'b1;
        rd_addr_out = 5'd0;
        cnt_d       = w_cnt_inc;
        if (mem_ready) begin
          load_data_d = w_load_ext;
          mem_req_d   = 1'b0;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else if (w_cnt_inc == C_TIMEOUT) begin
          load_data_d = 32'd0;
          mem_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // The held op is still on the inputs; leaving for IDLE here and
        // not re-decoding prevents it from issuing a second access.
        state_d = ST_IDLE;
        if (mem_we_q) begin
          rd_addr_out = 5'd0;
        end else begin
          rd_addr_out = rd_addr_in;
          rd_data_out = load_data_q;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      mem_wstrb_q    <= 4'b0000;
      load_data_q    <= 32'd0;
      funct3_q       <= 3'd0;
      off_q          <= 2'd0;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      load_data_q    <= load_data_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                              |
// | Purpose  : Self-checking bench for mem_access_unit: directed cases plus    |
// |            randomized ops compared against an arithmetic reference model. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_data_in, rs2_data_in, ram_addr_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [6:0]  opcode_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        stall_req, misalign_err, bus_err;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .rd_addr_in(rd_addr_in),
    .rd_data_in(rd_data_in), .rs2_data_in(rs2_data_in), .ram_addr_in(ram_addr_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .opcode_out(opcode_out), .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out),
    .stall_req(stall_req), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic bit m_legal(input logic [6:0] op, input int f3);
    if (op == OP_LOAD)  return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (op == OP_STORE) return (f3 <= 2);
    return 0;
  endfunction

  function automatic bit m_aligned(input int f3, input logic [31:0] addr);
    int size;
    size = 1 << (f3 % 4);
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] b, h;
    int off;
    off = addr % 4;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4: return b;
      5: return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] rs2);
    case (f3)
      0: return (rs2 & 32'hFF) * 32'h0101_0101;
      1: return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] m_wstrb(input int f3, input logic [31:0] addr);
    case (f3)
      0: return 32'd1 << (addr % 4);
      1: return 32'd3 << (addr % 4);
      default: return 32'd15;
    endcase
  endfunction

  task automatic drive_bubble();
    opcode_in   = OP_ALUI;
    funct3_in   = 3'd0;
    rd_addr_in  = 5'd0;
    rd_data_in  = 32'h0;
    rs2_data_in = 32'h0;
    ram_addr_in = 32'h0;
  endtask

  // Presents one op (called at posedge+1 with the unit idle), plays the RAM
  // (ready in BUSY cycle 'delay', or never when delay<0) and checks results.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] rdd, input logic [31:0] rs2,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input int delay, input string name);
    bit mem, ok, bad, tmo, seen_req, done;
    int exp_stalls, stalls, busy;
    logic [31:0] exp_rd_data;
    logic [4:0]  exp_rd_addr;
    mem        = (op == OP_LOAD) || (op == OP_STORE);
    ok         = mem && m_legal(op, f3) && m_aligned(f3, addr);
    bad        = mem && !ok;
    tmo        = ok && (delay < 0 || delay >= TIMEOUT);
    exp_stalls = !ok ? 0 : (tmo ? TIMEOUT + 1 : delay + 2);

    opcode_in = op; funct3_in = f3; rd_addr_in = rd;
    rd_data_in = rdd; rs2_data_in = rs2; ram_addr_in = addr;
    stalls = 0; busy = 0; seen_req = 0; done = 0;

    for (int cyc = 0; cyc < TIMEOUT + 8; cyc++) begin
      @(negedge clk);
      if (mem_req && !seen_req) begin
        seen_req = 1;
        check({name, " mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        check({name, " mem_we"}, {31'd0, mem_we}, {31'd0, op == OP_STORE});
        check({name, " mem_wstrb"}, {28'd0, mem_wstrb},
              (op == OP_STORE) ? m_wstrb(f3, addr) : 32'd0);
        if (op == OP_STORE) check({name, " mem_wdata"}, mem_wdata, m_wdata(f3, rs2));
      end
      if (!stall_req) begin
        done = 1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (busy == delay) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
        busy++;
      end
    end

    check({name, " completed"}, {31'd0, done}, 32'd1);
    check({name, " stall_cycles"}, stalls, exp_stalls);
    check({name, " req_issued"}, {31'd0, seen_req}, {31'd0, ok});

    exp_rd_addr = (op == OP_STORE || bad) ? 5'd0 : rd;
    exp_rd_data = (ok && op == OP_LOAD) ? (tmo ? 32'd0 : m_load(f3, addr, rdata)) : rdd;
    check({name, " opcode_out"}, {25'd0, opcode_out}, {25'd0, op});
    check({name, " rd_addr_out"}, {27'd0, rd_addr_out}, {27'd0, exp_rd_addr});
    if (op != OP_STORE) check({name, " rd_data_out"}, rd_data_out, exp_rd_data);
    check({name, " bus_err"}, {31'd0, bus_err}, {31'd0, tmo});
    check({name, " misalign_early"}, {31'd0, misalign_err}, 32'd0);

    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check({name, " misalign_err"}, {31'd0, misalign_err}, {31'd0, bad});
    drive_bubble();
    @(posedge clk);
    #1;
    check({name, " misalign_1cyc"}, {31'd0, misalign_err}, 32'd0);
    check({name, " bus_err_1cyc"}, {31'd0, bus_err}, 32'd0);
    check({name, " req_idle"}, {31'd0, mem_req}, 32'd0);
  endtask

  logic [6:0] alu_ops [4] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1100011};

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    int r, dly;

    rst = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    drive_bubble();
    #13;
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst misalign", {31'd0, misalign_err}, 32'd0);
    check("rst bus_err", {31'd0, bus_err}, 32'd0);
    check("rst stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_op(OP_ALU, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0, "alu_pass");
    run_op(OP_LOAD, 3'd0, 5'd3, 32'h0, 32'h0, 32'h103, 32'h80FF_FFFF, 0, "lb_sext");
    run_op(OP_STORE, 3'd1, 5'd9, 32'h0, 32'hAAAA_BEEF, 32'h202, 32'h0, 1, "sh");
    run_op(OP_LOAD, 3'd2, 5'd4, 32'h55, 32'h0, 32'h301, 32'h0, 0, "lw_misalign");
    run_op(OP_LOAD, 3'd5, 5'd6, 32'h0, 32'h0, 32'h400, 32'hDEAD_BEEF, -1, "lhu_timeout");
    run_op(OP_STORE, 3'd4, 5'd2, 32'h0, 32'h1, 32'h0, 32'h0, 0, "st_illegal");
    run_op(OP_LOAD, 3'd2, 5'd8, 32'h0, 32'h0, 32'h600, 32'hCAFE_F00D, 15, "lw_last_cycle");

    // Reset in the middle of an access
    opcode_in = OP_LOAD; funct3_in = 3'd2; rd_addr_in = 5'd7;
    rd_data_in = 32'h0; ram_addr_in = 32'h500;
    @(posedge clk);
    #1;
    check("midrst req_up", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst req_drop", {31'd0, mem_req}, 32'd0);
    drive_bubble();
    rd_data_in = 32'h7777;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("late_ready req", {31'd0, mem_req}, 32'd0);
    check("late_ready stall", {31'd0, stall_req}, 32'd0);
    check("late_ready data", rd_data_out, 32'h7777);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("late_ready after", rd_data_out, 32'h7777);
    check("late_ready bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    run_op(OP_LOAD, 3'd4, 5'd10, 32'h0, 32'h0, 32'h501, 32'h1234_A5FF, 2, "post_rst_lbu");

    // Randomized ops
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      op = OP_LOAD;
      else if (r < 8) op = OP_STORE;
      else            op = alu_ops[$urandom_range(0, 3)];
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      dly  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      run_op(op, f3, 5'($urandom), $urandom, $urandom, addr, $urandom, dly,
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
